imc_wb_initiator: RTL
=====================

Name: imc_wb_initiator

Overview:
- Wishbone classic single-transfer initiator that drives the IMC SRAM wrapper's slave side: write/read data bus, address, write-enable.
- Accepts commands (write weights/inputs, read buffers/outputs) from a local sequencer over a valid/ready port.
- Runs one bus cycle per command and returns one response per command through a small response FIFO.
- Aborts with an error response when the target never acknowledges.

Parameters:
- WIDTH_WB_DATA, 32, data bus width.
- WIDTH_ADD, 32, address width.
- TIMEOUT_CYCLES, 64, maximum wait for wbm_ack_i before abort (>=2).
- RSP_DEPTH, 4, response FIFO depth (power of 2, >=2).

Ports:
- clk  input  1  common clock.
- wb_rst_i  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when high with cmd_valid.
- cmd_we  input  1  1=write, 0=read.
- cmd_addr  input  WIDTH_ADD  target address.
- cmd_wdata  input  WIDTH_WB_DATA  write data.
- rsp_valid  output  1  response available at FIFO head.
- rsp_ready  input  1  consumer pops head.
- rsp_rdata  output  WIDTH_WB_DATA  read data; 0 for writes and errors.
- rsp_we  output  1  echo of command type.
- rsp_err  output  1  timeout abort.
- wbm_cyc_o  output  1  bus cycle.
- wbm_stb_o  output  1  strobe.
- wbm_we_o  output  1  write enable.
- wbm_sel_o  output  WIDTH_WB_DATA/8  byte selects, all ones during a cycle.
- wbm_adr_o  output  WIDTH_ADD  address.
- wbm_dat_o  output  WIDTH_WB_DATA  write data.
- wbm_dat_i  input  WIDTH_WB_DATA  read data.
- wbm_ack_i  input  1  acknowledge.
- busy  output  1  state != IDLE.
- err_count  output  8  saturating count of timeouts.

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, FIFO empty, timeout counter 0, err_count 0. Reset mid-cycle drops cyc/stb immediately and discards pending responses.
- State IDLE:
  - cmd_ready = !rsp_full.
  - On cmd_valid && cmd_ready: register we/addr/wdata onto the wbm_* outputs, set cyc=stb=1, sel all ones, clear the timeout counter, go to BUS.
  - The bus cycle is visible the cycle after acceptance.
- State BUS:
  - cmd_ready = 0; cyc/stb/we/adr/dat held stable.
  - wbm_ack_i sampled high: capture wbm_dat_i (reads) or 0 (writes), push {we, data, err=0}, drop cyc/stb on the same edge, return to IDLE.
  - Ack arriving in the first BUS cycle is legal; minimum command-to-response latency is 2 cycles.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: drop cyc/stb, push {we, 0, err=1}, increment err_count (saturates at 255), return to IDLE.
  - Ack and timeout on the same edge: ack wins, no error.
- Outside BUS: wbm_ack_i is ignored, and wbm_adr_o/wbm_dat_o hold their last values with cyc=0.
- Back-to-back commands: at least one IDLE cycle separates bus cycles; cyc is deasserted for at least 1 cycle.
- Response FIFO:
  - rsp_valid = !empty; head fields are driven directly.
  - Simultaneous push and pop while full is impossible, because IDLE gating guarantees a free slot for every in-flight command. Simultaneous push and pop at any other occupancy keeps the count.
  - Pointers wrap modulo RSP_DEPTH.
  - rsp_ready with empty FIFO: no effect.
- Never more than one outstanding bus cycle.

Decomposition:
- Package/header imc_wb_defs: state encoding (IDLE=0, BUS=1), err_count width, and the wrapper address-region constants for IB, WB, SA and OB used by sequencer and bench.
- Sub-module imc_rsp_fifo: synchronous FIFO, width 1+1+WIDTH_WB_DATA, depth RSP_DEPTH, with full/empty flags and async active-high reset.

Test Plan:
- Write 0x0000_00A5 to 0x3000_0004, ack after 1 BUS cycle -> cyc/stb high exactly 1 cycle, we=1, adr/dat match; response {we=1, rdata=0, err=0}.
- Read 0x3000_0010, ack after 5 cycles with dat_i=0x1234_5678 -> rsp_rdata=0x1234_5678, err=0; cyc/stb held stable all 5 cycles.
- Read with ack never asserted, TIMEOUT_CYCLES=64 -> cyc drops after 64 BUS cycles; response {err=1, rdata=0}; err_count=1. Repeat 256 timeouts -> err_count saturates at 255.
- Issue 4 commands with rsp_ready=0, ack immediately -> cmd_ready=0 after the 4th response is queued; pop one -> cmd_ready returns high next cycle; responses pop in issue order.
- Assert wb_rst_i during BUS with a queued response -> cyc/stb/rsp_valid low asynchronously; after release, next command completes normally.
- Ack and timeout coincide on cycle 64 -> normal response with err=0; err_count unchanged.

Source files
------------

// File: rtl/imc_wb_defs.sv
// Shared definitions for the IMC Wishbone initiator: FSM encoding, error counter
// sizing and the wrapper address map used by the sequencer and the bench.
package imc_wb_defs;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } wb_state_e;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Wrapper regions: input buffer, weight buffer, systolic array, output buffer
  localparam logic [31:0] REGION_MASK    = 32'hF000_0000;
  localparam logic [31:0] REGION_IB_BASE = 32'h1000_0000;
  localparam logic [31:0] REGION_WB_BASE = 32'h2000_0000;
  localparam logic [31:0] REGION_SA_BASE = 32'h3000_0000;
  localparam logic [31:0] REGION_OB_BASE = 32'h4000_0000;

  function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/imc_rsp_fifo.sv
// Small response FIFO with combinational head; one extra pointer bit tells
// full from empty.
module imc_rsp_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entries are cleared on reset so the head reads zero while empty after reset
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_q[gi] <= '0;
      end else if (push_ok && (wr_ptr_q[PTR_W-1:0] == PTR_W'(gi))) begin
        mem_q[gi] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/imc_wb_initiator.sv
// Wishbone classic single-transfer initiator: one bus cycle per accepted command,
// one response per command, timeout abort with a saturating error counter.
module imc_wb_initiator
  import imc_wb_defs::*;
#(
  parameter int WIDTH_WB_DATA  = 32,
  parameter int WIDTH_ADD      = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RSP_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       wb_rst_i,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_we,
  input  logic [WIDTH_ADD-1:0]       cmd_addr,
  input  logic [WIDTH_WB_DATA-1:0]   cmd_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH_WB_DATA-1:0]   rsp_rdata,
  output logic                       rsp_we,
  output logic                       rsp_err,
  output logic                       wbm_cyc_o,
  output logic                       wbm_stb_o,
  output logic                       wbm_we_o,
  output logic [WIDTH_WB_DATA/8-1:0] wbm_sel_o,
  output logic [WIDTH_ADD-1:0]       wbm_adr_o,
  output logic [WIDTH_WB_DATA-1:0]   wbm_dat_o,
  input  logic [WIDTH_WB_DATA-1:0]   wbm_dat_i,
  input  logic                       wbm_ack_i,
  output logic                       busy,
  output logic [ERR_CNT_W-1:0]       err_count
);

  localparam int SEL_W = WIDTH_WB_DATA / 8;
  localparam int RSP_W = WIDTH_WB_DATA + 2;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  wb_state_e              state_q, state_d;
  logic                   cyc_q, cyc_d;
  logic                   we_q, we_d;
  logic [WIDTH_ADD-1:0]   adr_q, adr_d;
  logic [WIDTH_WB_DATA-1:0] dat_q, dat_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic                   accept;
  logic                   bus_ack;
  logic                   bus_timeout;
  logic                   rsp_push;
  logic [WIDTH_WB_DATA-1:0] rsp_data;
  logic [RSP_W-1:0]       rsp_push_data;
  logic [RSP_W-1:0]       rsp_head;
  logic                   rsp_full;
  logic                   rsp_empty;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cmd_valid && !rsp_full) state_d = ST_BUS;
      ST_BUS:  if (wbm_ack_i || (to_cnt_q == TO_LAST)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Ack has priority over a timeout landing on the same edge
  always_comb begin
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    bus_ack     = 1'b0;
    bus_timeout = 1'b0;
    unique case (state_q)
      ST_IDLE: cmd_ready = !rsp_full;
      ST_BUS: begin
        busy        = 1'b1;
        bus_ack     = wbm_ack_i;
        bus_timeout = !wbm_ack_i && (to_cnt_q == TO_LAST);
      end
      default: ;
    endcase
  end

  assign accept        = cmd_valid && cmd_ready;
  assign rsp_push      = bus_ack || bus_timeout;
  assign rsp_data      = (bus_ack && !we_q) ? wbm_dat_i : '0;
  assign rsp_push_data = {we_q, bus_timeout, rsp_data};

  always_comb begin
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    to_cnt_d  = to_cnt_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      cyc_d    = 1'b1;
      we_d     = cmd_we;
      adr_d    = cmd_addr;
      dat_d    = cmd_wdata;
      to_cnt_d = '0;
    end else if (rsp_push) begin
      cyc_d = 1'b0;
    end else if (busy) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    if (bus_timeout) err_cnt_d = err_sat_inc(err_cnt_q);
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      to_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      to_cnt_q  <= to_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // A slot is always free for the in-flight command, so push never meets full
  imc_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (wb_rst_i),
    .push_i      (rsp_push),
    .push_data_i (rsp_push_data),
    .pop_i       (rsp_ready),
    .head_o      (rsp_head),
    .full_o      (rsp_full),
    .empty_o     (rsp_empty)
  );

  assign rsp_valid = !rsp_empty;
  assign {rsp_we, rsp_err, rsp_rdata} = rsp_head;

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = {SEL_W{cyc_q}};
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign err_count = err_cnt_q;

endmodule
